dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Two-port controller in front of the core's single-port data memory (64-bit words, combinational read, synchronous full-word write). It arbitrates between the core load/store unit (port 0) and the DMA/debug port (port 1). It converts byte, half and word accesses into aligned 64-bit word accesses: loads are extracted and sign/zero-extended, and sub-word stores are done as read-modify-write. One transaction is in flight at a time.

## Interface
Parameters:
- `AW`, 64: address width (byte address).
- `DW`, 64: data width; only 64 is supported.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req0`, `req1`  in  1  request from port 0 (core) / port 1 (DMA).
- `we0`, `we1`  in  1  1 = store, 0 = load.
- `addr0`, `addr1`  in  AW  byte address.
- `wdata0`, `wdata1`  in  DW  store data, right-justified.
- `size0`, `size1`  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- `uns0`, `uns1`  in  1  load zero-extends when 1.
- `ack0`, `ack1`  out  1  one-cycle completion pulse.
- `rdata`  out  DW  load result, valid with ack.
- `err`  out  1  misaligned flag, valid with ack.
- `mem_A`  out  AW  memory byte address, always 8-aligned.
- `mem_WD`  out  DW  memory write data.
- `mem_WE`  out  1  memory write enable.
- `mem_RD`  in  DW  memory read data, combinational from `mem_A`.

## Operation
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE: on any reqN, select a port and latch its we/addr/wdata/size/uns and the port id.
  - Misaligned access (addr[size-1:0] != 0) goes to RESP with err=1.
  - Otherwise go to ACCESS.
- ACCESS: `mem_A = {addr[63:3],3'b000}`.
  - Load: capture the extracted, extended value into rdata, then go to RESP.
  - Dword store: mem_WE=1, mem_WD=wdata, then go to RESP.
  - Sub-word store: latch mem_RD into the merge register, then go to WRITE.
- WRITE: mem_WE=1, with mem_WD = merge word with lanes [8*addr[2:0] +: 8<<size] replaced by the low bytes of wdata. Then go to RESP.
- RESP: pulse ackN for the latched port, then go to IDLE.
- Lane rules:
  - Little-endian.
  - Load value = mem_RD >> (8*addr[2:0]), truncated to 8<<size bits.
  - Sign-extended unless uns=1 or size=3.
  - uns is ignored for stores.
- Arbitration: both requests raised in IDLE → fixed priority to port 0. With the configuration macro enabled, round-robin is used instead.
- Handshake:
  - Requester holds req and fields stable until it samples ack=1.
  - Requester drops req or presents a new request at that same edge.
  - A request seen in IDLE is always accepted; there is no back-pressure beyond FSM occupancy.
- mem_WE is asserted only in ACCESS (dword store) or WRITE (sub-word store), never on error or load.

## Timing
- Cycle 0 is the IDLE cycle that accepts the request. Registered ack is high in:
  - Load: cycle 2.
  - Dword store: cycle 2, written at the end of cycle 1.
  - Sub-word store: cycle 3, written at the end of cycle 2.
  - Misaligned: cycle 1.
- Next request is accepted at the earliest in the IDLE cycle after RESP.
- Reset values: state=IDLE, ack0=ack1=0, err=0, rdata=0, merge=0, latched fields 0, RR pointer favours port 0.
- mem_A=0, mem_WD=0, mem_WE=0 whenever the FSM is in IDLE or RESP, and in reset.
- Reset mid-transaction: return to IDLE on that edge, no ack, no write.
  - Reset during ACCESS of a sub-word store leaves memory untouched.
- A req arriving while busy waits; it is sampled in the next IDLE.
- rdata holds its value until the next load completes; it is not cleared on store ack.

## Configuration
- `DMEM_CTRL_RR_EN` defined: two-way round-robin.
  - On a conflict, grant the port not granted last; the pointer updates on each grant.
  - A lone request is always granted.
- Undefined: fixed priority, port 0 always wins, and port 1 may starve under continuous port-0 traffic.

## Structure
- Package `dmem_ctrl_pkg` holds:
  - State enum (IDLE/ACCESS/WRITE/RESP).
  - Size encoding constants (SZ_B/SZ_H/SZ_W/SZ_D).
  - Port-id constants.
- Sub-module `dmem_lane_align` (combinational) holds both:
  - Load extract/extend from (mem_RD, addr[2:0], size, uns).
  - Store merge from (old word, wdata, addr[2:0], size).
- The top level holds the FSM, arbiter and registers.

## Test plan
- Port 0 dword store 0x1122334455667788 at 0x40, then load dword at 0x40 → mem_WE high in cycle 1 only; load ack in cycle 2 with rdata=0x1122334455667788.
- Word at 0x40 preset to 0xFFFF_FFFF_FFFF_FFFF; port 1 byte store 0x5A at 0x43 → ack in cycle 3; word becomes 0xFFFF_FFFF_5AFF_FFFF.
- Word at 0x48 = 0x0000_0000_0080_0000; byte load at 0x4A with uns=0 → rdata=0xFFFF_FFFF_FFFF_FF80; with uns=1 → 0x80.
- Half store at 0x41 → ack in cycle 1 with err=1, mem_WE never asserted, memory unchanged.
- req0 and req1 held continuously:
  - Macro defined: acks alternate 0,1,0,1.
  - Macro undefined: only ack0 pulses.
- rst asserted during ACCESS of a byte store → next cycle state IDLE, no ack, target word unchanged.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// dmem_ctrl_pkg: shared types and constants for the data-memory controller.
// Holds FSM state enum, access-size codes, port ids and the alignment check.
package dmem_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WRITE,
      RESP
   } state_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;
   localparam logic [1:0] SZ_D = 2'd3;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

   // true when the low address bits are not a multiple of the access size
   function automatic logic misaligned(
      input logic [2:0] a,
      input logic [1:0] sz
   );
      case (sz)
         SZ_B:    return 1'b0;
         SZ_H:    return a[0];
         SZ_W:    return |a[1:0];
         default: return |a;
      endcase
   endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: bundle of both requester ports and the memory-side signals.
// slave = controller view; master = requesters plus the memory array.
interface dmem_ctrl_if #(
   parameter int AW = 64,
   parameter int DW = 64
);
   logic          req0, req1;
   logic          we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1;
   logic [1:0]    size0, size1;
   logic          uns0, uns1;
   logic          ack0, ack1;
   logic [DW-1:0] rdata;
   logic          err;
   logic [AW-1:0] mem_A;
   logic [DW-1:0] mem_WD;
   logic          mem_WE;
   logic [DW-1:0] mem_RD;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1,
      input  wdata0, wdata1, size0, size1, uns0, uns1,
      input  mem_RD,
      output ack0, ack1, rdata, err,
      output mem_A, mem_WD, mem_WE
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1,
      output wdata0, wdata1, size0, size1, uns0, uns1,
      output mem_RD,
      input  ack0, ack1, rdata, err,
      input  mem_A, mem_WD, mem_WE
   );

endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: combinational little-endian lane logic for 64-bit words.
// In: rd/old word, wd store data, off byte offset, size, uns. Out: ld, st.
module dmem_lane_align
   import dmem_ctrl_pkg::*;
(
   input  logic [63:0] rd,
   input  logic [63:0] old,
   input  logic [63:0] wd,
   input  logic [2:0]  off,
   input  logic [1:0]  size,
   input  logic        uns,
   output logic [63:0] ld,
   output logic [63:0] st
);

   logic [5:0]  sa;
   logic [63:0] sh;
   logic [63:0] msk;

   assign sa = {off, 3'b000};

   always_comb begin
      sh  = rd >> sa;
      ld  = sh;
      msk = '1;
      case (size)
         SZ_B: begin
            ld  = {{56{~uns & sh[7]}}, sh[7:0]};
            msk = 64'h0000_0000_0000_00ff;
         end
         SZ_H: begin
            ld  = {{48{~uns & sh[15]}}, sh[15:0]};
            msk = 64'h0000_0000_0000_ffff;
         end
         SZ_W: begin
            ld  = {{32{~uns & sh[31]}}, sh[31:0]};
            msk = 64'h0000_0000_ffff_ffff;
         end
         default: begin
            ld  = sh;
            msk = '1;
         end
      endcase
      // replace only the addressed lanes of the old word
      st = (old & ~(msk << sa)) | ((wd & msk) << sa);
   end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: two-port arbiter/aligner in front of a 64-bit single-port RAM.
// Ports: clk, rst (sync, high), bus (dmem_ctrl_if.slave). DMEM_CTRL_RR_EN = RR.
module dmem_ctrl
   import dmem_ctrl_pkg::*;
#(
   parameter int AW = 64,
   parameter int DW = 64
) (
   input logic        clk,
   input logic        rst,
   dmem_ctrl_if.slave bus
);

   state_t        state, nxt;
   logic          pid_q, we_q, uns_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q, merge_q, rdata_q;
   logic [1:0]    size_q;
   logic          ack0_q, ack1_q, err_q;

   logic          any, gnt1;
   logic          s_we, s_uns, s_mis;
   logic [AW-1:0] s_addr;
   logic [DW-1:0] s_wdata;
   logic [1:0]    s_size;
   logic          sub;
   logic [DW-1:0] ld_val, st_val;
   logic [AW-1:0] mem_a;
   logic [DW-1:0] mem_wd;
   logic          mem_we;

   assign any = bus.req0 | bus.req1;

`ifdef DMEM_CTRL_RR_EN
   // rr_q=1 means port 1 wins the next conflict
   logic rr_q;
   assign gnt1 = bus.req1 & (~bus.req0 | rr_q);
   always_ff @(posedge clk) begin
      if (rst)
         rr_q <= 1'b0;
      else if (state == IDLE && any)
         rr_q <= ~gnt1;
   end
`else
   assign gnt1 = bus.req1 & ~bus.req0;
`endif

   assign s_we    = gnt1 ? bus.we1    : bus.we0;
   assign s_addr  = gnt1 ? bus.addr1  : bus.addr0;
   assign s_wdata = gnt1 ? bus.wdata1 : bus.wdata0;
   assign s_size  = gnt1 ? bus.size1  : bus.size0;
   assign s_uns   = gnt1 ? bus.uns1   : bus.uns0;
   assign s_mis   = misaligned(s_addr[2:0], s_size);
   assign sub     = (size_q != SZ_D);

   dmem_lane_align u_align (
      .rd   (bus.mem_RD),
      .old  (merge_q),
      .wd   (wdata_q),
      .off  (addr_q[2:0]),
      .size (size_q),
      .uns  (uns_q),
      .ld   (ld_val),
      .st   (st_val)
   );

   always_comb begin
      nxt    = state;
      mem_a  = '0;
      mem_wd = '0;
      mem_we = 1'b0;
      case (state)
         IDLE: begin
            if (any)
               nxt = s_mis ? RESP : ACCESS;
         end
         ACCESS: begin
            mem_a = {addr_q[AW-1:3], 3'b000};
            if (we_q && !sub) begin
               mem_we = 1'b1;
               mem_wd = wdata_q;
            end
            nxt = (we_q && sub) ? WRITE : RESP;
         end
         WRITE: begin
            mem_a  = {addr_q[AW-1:3], 3'b000};
            mem_we = 1'b1;
            mem_wd = st_val;
            nxt    = RESP;
         end
         default: nxt = IDLE;
      endcase
      // reset aborts the access on the same cycle, so no write escapes
      if (rst) begin
         mem_a  = '0;
         mem_wd = '0;
         mem_we = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         pid_q   <= PORT0;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         size_q  <= SZ_B;
         merge_q <= '0;
         rdata_q <= '0;
         ack0_q  <= 1'b0;
         ack1_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state  <= nxt;
         ack0_q <= 1'b0;
         ack1_q <= 1'b0;
         err_q  <= 1'b0;
         if (state == IDLE && any) begin
            pid_q   <= gnt1;
            we_q    <= s_we;
            addr_q  <= s_addr;
            wdata_q <= s_wdata;
            size_q  <= s_size;
            uns_q   <= s_uns;
            if (s_mis) begin
               ack0_q <= ~gnt1;
               ack1_q <= gnt1;
               err_q  <= 1'b1;
            end
         end
         if (state == ACCESS) begin
            if (!we_q)
               rdata_q <= ld_val;
            else if (sub)
               merge_q <= bus.mem_RD;
         end
         if ((state == ACCESS || state == WRITE)
             && nxt == RESP) begin
            ack0_q <= ~pid_q;
            ack1_q <= pid_q;
         end
      end
   end

   assign bus.ack0   = ack0_q;
   assign bus.ack1   = ack1_q;
   assign bus.err    = err_q;
   assign bus.rdata  = rdata_q;
   assign bus.mem_A  = mem_a;
   assign bus.mem_WD = mem_wd;
   assign bus.mem_WE = mem_we;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed table, arbitration, reset-abort and random checks
// of dmem_ctrl against a byte-array reference model of the memory.
module tb_dmem_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   dmem_ctrl_if #(.AW(64), .DW(64)) bus ();

   dmem_ctrl #(.AW(64), .DW(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [63:0] mem [0:63];
   logic        pre_we;
   logic [5:0]  pre_idx;
   logic [63:0] pre_val;

   assign bus.mem_RD = mem[bus.mem_A[8:3]];

   always @(posedge clk) begin
      if (bus.mem_WE)
         mem[bus.mem_A[8:3]] <= bus.mem_WD;
      else if (pre_we)
         mem[pre_idx] <= pre_val;
   end

   logic [7:0]  refb [0:511];
   logic [63:0] last_rd;
   int          checks;
   int          failures;

   typedef struct {
      bit          p;
      bit          we;
      logic [63:0] a;
      logic [63:0] wd;
      logic [1:0]  sz;
      bit          u;
      int          lat;
      bit          err;
      logic [63:0] rd;
   } vec_t;

   vec_t tv [16];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic logic [63:0] ref_word(input int idx);
      logic [63:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         v = v | (64'(refb[idx*8+i]) << (8*i));
      return v;
   endfunction

   task automatic model(input bit we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [1:0] sz,
                        input bit u, output int lat, output bit e,
                        output logic [63:0] rd);
      int nb;
      int base;
      logic [63:0] v;
      nb   = 1 << sz;
      base = int'(a[8:0]);
      e    = (base % nb) != 0;
      rd   = last_rd;
      lat  = 1;
      if (!e && !we) begin
         v = '0;
         for (int i = 0; i < nb; i++)
            v = v | (64'(refb[base+i]) << (8*i));
         if (!u && nb < 8 && v[8*nb-1])
            v = v | (~64'd0 << (8*nb));
         rd      = v;
         last_rd = v;
         lat     = 2;
      end else if (!e) begin
         for (int i = 0; i < nb; i++)
            refb[base+i] = 8'(wd >> (8*i));
         lat = (nb == 8) ? 2 : 3;
      end
   endtask

   task automatic do_txn(input bit p, input bit we, input logic [63:0] a,
                         input logic [63:0] wd, input logic [1:0] sz,
                         input bit u, output int lat, output bit ap,
                         output bit e, output logic [63:0] rd,
                         output logic [7:0] wem);
      if (!p) begin
         bus.we0 = we; bus.addr0 = a; bus.wdata0 = wd;
         bus.size0 = sz; bus.uns0 = u; bus.req0 = 1'b1;
      end else begin
         bus.we1 = we; bus.addr1 = a; bus.wdata1 = wd;
         bus.size1 = sz; bus.uns1 = u; bus.req1 = 1'b1;
      end
      lat = 0; ap = 1'b0; e = 1'b0; rd = '0; wem = '0;
      for (int k = 1; k <= 8; k++) begin
         if (bus.mem_WE) wem[k-1] = 1'b1;
         @(posedge clk); #1;
         if (bus.ack0 || bus.ack1) begin
            lat = k; ap = bus.ack1; e = bus.err; rd = bus.rdata;
            break;
         end
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      @(posedge clk); #1;
      chk("ack_one_cycle", {62'd0, bus.ack1, bus.ack0}, 64'd0);
   endtask

   task automatic run(input string nm, input bit p, input bit we,
                      input logic [63:0] a, input logic [63:0] wd,
                      input logic [1:0] sz, input bit u, input bit tbl,
                      input int tlat, input bit terr,
                      input logic [63:0] trd);
      int          mlat, glat, xl;
      bit          merr, gerr, ap, xe;
      logic [63:0] mrd, grd, xrd;
      logic [7:0]  gwem, xwem;
      model(we, a, wd, sz, u, mlat, merr, mrd);
      do_txn(p, we, a, wd, sz, u, glat, ap, gerr, grd, gwem);
      xl  = tbl ? tlat : mlat;
      xe  = tbl ? terr : merr;
      xrd = tbl ? trd  : mrd;
      xwem = '0;
      if (we && !xe) xwem[xl-1] = 1'b1;
      chk({nm, ".lat"},  64'(glat), 64'(xl));
      chk({nm, ".port"}, 64'(ap),   64'(p));
      chk({nm, ".err"},  64'(gerr), 64'(xe));
      chk({nm, ".rdata"}, grd, xrd);
      chk({nm, ".we_cyc"}, 64'(gwem), 64'(xwem));
      chk({nm, ".mem"}, mem[a[8:3]], ref_word(int'(a[8:3])));
   endtask

   initial begin
      int          n;
      bit          seq [4];
      bit          exp1;
      logic [63:0] a, wd;
      logic [1:0]  sz;
      checks = 0; failures = 0; last_rd = '0;
      for (int i = 0; i < 512; i++) refb[i] = 8'h00;
      {bus.req0, bus.req1, bus.we0, bus.we1} = '0;
      {bus.addr0, bus.addr1, bus.wdata0, bus.wdata1} = '0;
      {bus.size0, bus.size1, bus.uns0, bus.uns1} = '0;

      tv[0]  = '{0, 1, 64'h40, 64'h1122334455667788, 3, 0, 2, 0, 64'h0};
      tv[1]  = '{0, 0, 64'h40, 64'h0, 3, 0, 2, 0, 64'h1122334455667788};
      tv[2]  = '{0, 1, 64'h40, '1, 3, 0, 2, 0, 64'h1122334455667788};
      tv[3]  = '{1, 1, 64'h43, 64'h5a, 0, 0, 3, 0, 64'h1122334455667788};
      tv[4]  = '{1, 0, 64'h40, 64'h0, 3, 0, 2, 0, 64'hffffffff5affffff};
      tv[5]  = '{0, 1, 64'h48, 64'h800000, 3, 0, 2, 0, 64'hffffffff5affffff};
      tv[6]  = '{0, 0, 64'h4a, 64'h0, 0, 0, 2, 0, 64'hffffffffffffff80};
      tv[7]  = '{0, 0, 64'h4a, 64'h0, 0, 1, 2, 0, 64'h80};
      tv[8]  = '{1, 1, 64'h41, 64'h1234, 1, 0, 1, 1, 64'h80};
      tv[9]  = '{0, 0, 64'h40, 64'h0, 3, 0, 2, 0, 64'hffffffff5affffff};
      tv[10] = '{1, 0, 64'h44, 64'h0, 2, 0, 2, 0, 64'hffffffffffffffff};
      tv[11] = '{0, 0, 64'h4a, 64'h0, 1, 0, 2, 0, 64'h80};
      tv[12] = '{1, 0, 64'h42, 64'h0, 2, 0, 1, 1, 64'h80};
      tv[13] = '{0, 1, 64'h4c, 64'hdeadbeefcafef00d, 2, 0, 3, 0, 64'h80};
      tv[14] = '{0, 0, 64'h4c, 64'h0, 2, 0, 2, 0, 64'hffffffffcafef00d};
      tv[15] = '{0, 0, 64'h4c, 64'h0, 2, 1, 2, 0, 64'h00000000cafef00d};

      rst = 1'b1;
      pre_we = 1'b1;
      pre_val = '0;
      for (int i = 0; i < 64; i++) begin
         pre_idx = 6'(i);
         @(posedge clk); #1;
      end
      pre_we = 1'b0;
      chk("rst.ack0",   64'(bus.ack0), 64'd0);
      chk("rst.ack1",   64'(bus.ack1), 64'd0);
      chk("rst.err",    64'(bus.err),  64'd0);
      chk("rst.rdata",  bus.rdata,     64'd0);
      chk("rst.mem_A",  bus.mem_A,     64'd0);
      chk("rst.mem_WD", bus.mem_WD,    64'd0);
      chk("rst.mem_WE", 64'(bus.mem_WE), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++)
         run($sformatf("vec%0d", i), tv[i].p, tv[i].we, tv[i].a,
             tv[i].wd, tv[i].sz, tv[i].u, 1'b1, tv[i].lat,
             tv[i].err, tv[i].rd);

      // both ports held continuously from a fresh reset
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_rd = '0;
      bus.we0 = 0; bus.addr0 = 64'h40; bus.size0 = 2'd3; bus.uns0 = 0;
      bus.we1 = 0; bus.addr1 = 64'h48; bus.size1 = 2'd3; bus.uns1 = 0;
      bus.req0 = 1'b1; bus.req1 = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 4; c++) begin
         @(posedge clk); #1;
         if (bus.ack0 && bus.ack1)
            chk("arb.both_ack", 64'd1, 64'd0);
         if (bus.ack0 || bus.ack1) begin
            seq[n] = bus.ack1;
            n++;
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      @(posedge clk); #1;
      chk("arb.count", 64'(n), 64'd4);
      for (int i = 0; i < 4; i++) begin
`ifdef DMEM_CTRL_RR_EN
         exp1 = (i % 2) == 1;
`else
         exp1 = 1'b0;
`endif
         chk($sformatf("arb.ack%0d", i), 64'(seq[i]), 64'(exp1));
      end
`ifdef DMEM_CTRL_RR_EN
      last_rd = ref_word(9);
`else
      last_rd = ref_word(8);
`endif
      chk("arb.rdata", bus.rdata, last_rd);

      // reset during ACCESS aborts byte and dword stores
      for (int j = 0; j < 2; j++) begin
         bus.we0 = 1; bus.addr0 = 64'h50; bus.uns0 = 0;
         bus.size0 = (j == 0) ? 2'd0 : 2'd3;
         bus.wdata0 = 64'h0123_4567_89ab_cdef;
         bus.req0 = 1'b1;
         @(posedge clk); #1;
         bus.req0 = 1'b0;
         rst = 1'b1;
         #1;
         chk($sformatf("rstmid%0d.we", j), 64'(bus.mem_WE), 64'd0);
         @(posedge clk); #1;
         rst = 1'b0;
         chk($sformatf("rstmid%0d.ack", j),
             {62'd0, bus.ack1, bus.ack0}, 64'd0);
         chk($sformatf("rstmid%0d.mem_A", j), bus.mem_A, 64'd0);
         @(posedge clk); #1;
         @(posedge clk); #1;
         chk($sformatf("rstmid%0d.noack", j),
             {62'd0, bus.ack1, bus.ack0}, 64'd0);
         chk($sformatf("rstmid%0d.word", j), mem[10], ref_word(10));
         chk($sformatf("rstmid%0d.rdata", j), bus.rdata, 64'd0);
      end
      last_rd = '0;
      run("after_rst", 0, 0, 64'h50, 64'h0, 2'd3, 0, 1'b0, 0, 0, 64'h0);

      for (int i = 0; i < 300; i++) begin
         sz = 2'($urandom_range(0, 3));
         a  = 64'($urandom_range(0, 511));
         if ($urandom_range(0, 3) != 0)
            a = a & ~((64'd1 << sz) - 64'd1);
         wd = {$urandom, $urandom};
         run($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), a, wd, sz,
             1'($urandom_range(0, 1)), 1'b0, 0, 0, 64'h0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
